// File: rtl/fetcher.sv
// Instruction fetcher: issues one ICache request at a time, hands each returned
// instruction to the branch predictor, and buffers {instr, pc, pred_jump} in a
// circular instruction queue for the decoder. A ROB flush empties the queue and
// redirects the pc; a response still in flight at flush time is dropped.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   rdy_i                  global enable; low freezes all state
//   ic_req_valid_o/pc_o    fetch request to ICache (pc_o always mirrors pc)
//   ic_rsp_valid_i/instr_i single-cycle ICache response
//   pred_instr_valid_o,
//   pred_instr_o,
//   pred_cur_pc_o          instruction presented to the branch predictor
//   pred_predict_pc_i      predictor's next pc (combinational)
//   iq_out_*               queue head to decoder; iq_out_ready_i pops it
//   flush_i, flush_pc_i    misprediction rollback and corrected pc
module fetcher #(
  parameter int unsigned IqDepth = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rdy_i,
  output logic        ic_req_valid_o,
  output logic [31:0] ic_req_pc_o,
  input  logic        ic_rsp_valid_i,
  input  logic [31:0] ic_rsp_instr_i,
  output logic        pred_instr_valid_o,
  output logic [31:0] pred_instr_o,
  output logic [31:0] pred_cur_pc_o,
  input  logic [31:0] pred_predict_pc_i,
  output logic        iq_out_valid_o,
  output logic [31:0] iq_out_instr_o,
  output logic [31:0] iq_out_pc_o,
  output logic        iq_out_pred_jump_o,
  input  logic        iq_out_ready_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i
);

  localparam int unsigned PtrW = $clog2(IqDepth);
  localparam int unsigned CntW = $clog2(IqDepth + 1);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [31:0]       instr_mem_q [IqDepth];
  logic [31:0]       pc_mem_q    [IqDepth];
  logic [IqDepth-1:0] jump_mem_q;

  logic q_empty, q_full, active;
  logic req, rsp_accept, push, pop, pred_jump;

  assign q_empty = (cnt_q == '0);
  assign q_full  = (cnt_q == CntW'(IqDepth));
  // Gate with rst_ni so nothing is requested while reset is still asserted.
  assign active  = rdy_i & rst_ni;

  assign req        = active & (state_q == StIdle) & ~flush_i & ~q_full;
  assign rsp_accept = active & (state_q == StWait) & ic_rsp_valid_i & ~flush_i;
  assign push       = rsp_accept;
  assign pop        = active & ~q_empty & iq_out_ready_i & ~flush_i;
  assign pred_jump  = (pred_predict_pc_i != (pc_q + 32'd4));

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (rdy_i) begin
      unique case (state_q)
        StIdle: begin
          if (req) state_d = StWait;
        end
        StWait: begin
          // A response always retires the request, even when a flush drops it.
          if (ic_rsp_valid_i)  state_d = StIdle;
          else if (flush_i)    state_d = StDiscard;
        end
        StDiscard: begin
          if (ic_rsp_valid_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    ic_req_valid_o     = req;
    pred_instr_valid_o = rsp_accept;
  end

  assign ic_req_pc_o   = pc_q;
  assign pred_instr_o  = ic_rsp_instr_i;
  assign pred_cur_pc_o = pc_q;

  assign iq_out_valid_o     = ~q_empty;
  assign iq_out_instr_o     = instr_mem_q[head_q];
  assign iq_out_pc_o        = pc_mem_q[head_q];
  assign iq_out_pred_jump_o = jump_mem_q[head_q];

  // Datapath next state: pc, pointers, occupancy
  always_comb begin
    pc_d   = pc_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (rdy_i) begin
      if (flush_i) begin
        pc_d   = flush_pc_i;
        head_d = '0;
        tail_d = '0;
        cnt_d  = '0;
      end else begin
        if (push) begin
          tail_d = tail_q + PtrW'(1);
          pc_d   = pred_predict_pc_i;
        end
        if (pop) head_d = head_q + PtrW'(1);
        unique case ({push, pop})
          2'b10:   cnt_d = cnt_q + CntW'(1);
          2'b01:   cnt_d = cnt_q - CntW'(1);
          default: cnt_d = cnt_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q   <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Queue storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[tail_q] <= ic_rsp_instr_i;
      pc_mem_q[tail_q]    <= pc_q;
      jump_mem_q[tail_q]  <= pred_jump;
    end
  end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 Parameter: IQ_DEPTH, 8, instruction-queue entries (power of two, >=2).
REQ-002 Port: clk  input  1  system clock, all state on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous and active-low.
REQ-004 Port: rdy  input  1  global enable; low freezes all state.
REQ-005 Port: ic_req_valid  output  1  one-cycle fetch request to ICache.
REQ-006 Port: ic_req_pc  output  32  fetch address, equals internal pc.
REQ-007 Port: ic_rsp_valid  input  1  one-cycle pulse, instruction returned.
REQ-008 Port: ic_rsp_instr  input  32  returned instruction word.
REQ-009 Port: pred_instr_valid  output  1  instruction presented to branch predictor.
REQ-010 Port: pred_instr  output  32  instruction to predictor (ic_rsp_instr).
REQ-011 Port: pred_cur_pc  output  32  pc of that instruction.
REQ-012 Port: pred_predict_pc  input  32  predictor's next pc (combinational).
REQ-013 Port: iq_out_valid  output  1  queue head valid to decoder.
REQ-014 Port: iq_out_instr  output  32  head instruction.
REQ-015 Port: iq_out_pc  output  32  head pc.
REQ-016 Port: iq_out_pred_jump  output  1  head predicted taken.
REQ-017 Port: iq_out_ready  input  1  decoder accepts head this cycle.
REQ-018 Port: flush  input  1  ROB misprediction rollback.
REQ-019 Port: flush_pc  input  32  corrected pc.

Function
REQ-020 FSM states IDLE, WAIT, DISCARD; at most one ICache request outstanding.
REQ-021 IDLE: ic_req_valid=1 (combinational) iff rdy & ~flush & count<IQ_DEPTH; that cycle state->WAIT.
REQ-022 ICache contract: exactly one ic_rsp_valid pulse per request, no earlier than the cycle after the request.
REQ-023 WAIT & ic_rsp_valid & ~flush: pred_instr_valid=1, pred_cur_pc=pc, pred_instr=ic_rsp_instr, all combinational same cycle.
REQ-024 Same cycle edge: push {instr, pc, pred_jump = (pred_predict_pc != pc+4)}, pc<=pred_predict_pc, state->IDLE.
REQ-025 pred_instr_valid=0 in all other cycles; pred_instr/pred_cur_pc don't-care then.
REQ-026 Latency: request cycle T, response T+k -> entry on iq_out at T+k+1 (if queue was empty); next request earliest T+k+1.
REQ-027 Queue: circular, head/tail pointers log2(IQ_DEPTH) bits wrapping modulo IQ_DEPTH, count 0..IQ_DEPTH.
REQ-028 iq_out_valid = (count!=0); iq_out_* read combinationally from head entry.
REQ-029 Pop when iq_out_valid & iq_out_ready & ~flush: head advances, count-1.
REQ-030 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-031 Overflow impossible by REQ-021; pop on empty ignored.
REQ-032 flush (any state): queue emptied (head=tail, count=0), pc<=flush_pc; flush beats push and pop in same cycle.
REQ-033 flush in WAIT without ic_rsp_valid -> DISCARD; flush in WAIT with ic_rsp_valid -> IDLE, response dropped.
REQ-034 DISCARD: no request; on ic_rsp_valid drop it, ->IDLE; further flush updates pc, stays DISCARD.
REQ-035 flush in IDLE: no request that cycle, state stays IDLE.
REQ-036 rdy=0: no state, pointer, pc or queue change; ic_req_valid=0, pred_instr_valid=0; iq_out_* hold.
REQ-037 pc arithmetic 32-bit, wraps modulo 2^32.

Reset
REQ-038 rst low (asynchronous): state=IDLE, pc=0, head=tail=0, count=0.
REQ-039 During reset outputs: ic_req_valid=0, pred_instr_valid=0, iq_out_valid=0, ic_req_pc=0.
REQ-040 Reset mid-WAIT: any later ic_rsp_valid while in IDLE is ignored; first request after release has ic_req_pc=0.

Verification
REQ-041 Reset release, ICache 2-cycle latency, NOP at every pc, predictor returns pc+4 -> requests at pc 0,4,8..., iq_out_pc 0,4,8 in order, pred_jump=0.
REQ-042 Response JAL at pc 0x10, pred_predict_pc=0x40 -> entry pc 0x10 pred_jump=1, next ic_req_pc=0x40.
REQ-043 iq_out_ready=0, IQ_DEPTH=8 -> exactly 8 pushes, ic_req_valid stays 0; one pop -> one new request.
REQ-044 flush (flush_pc=0x200) in WAIT, response 3 cycles later -> response dropped, queue empty, next ic_req_pc=0x200.
REQ-045 flush coincident with ic_rsp_valid and pop, count=3 -> count=0, no push, next ic_req_pc=flush_pc.
REQ-046 rdy low 5 cycles while WAIT with queue count=2 -> count, pc, state unchanged; operation resumes identically.
